// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: Wishbone-classic fetch master, prefetch FIFO and registered IF/ID output.
// Misaligned targets and bus errors are carried as exception flags alongside the instruction.
module if_prefetch_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_stall_i,
  input  logic [1:0]      if_pc_sel_i,
  input  logic [XLEN-1:0] pc_branch_address_i,
  input  logic [XLEN-1:0] pc_jump_address_i,
  output logic [XLEN-1:0] iwbm_addr_o,
  output logic            iwbm_cyc_o,
  output logic            iwbm_stb_o,
  input  logic [31:0]     iwbm_dat_i,
  input  logic            iwbm_ack_i,
  input  logic            iwbm_err_i,
  output logic [31:0]     id_instruction_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_add4_o,
  output logic            id_valid_o,
  output logic            id_exc_addr_o,
  output logic            id_exc_bus_o
);
  localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALT} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, addr_plus4;
  logic [XLEN-1:0] fifo_pc_q [DEPTH];
  logic [31:0]     fifo_inst_q [DEPTH];
  logic [DEPTH-1:0] fifo_ea_q, fifo_eb_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_popped, count_after;

  logic            redirect, pop, space, resp, fifo_empty;
  logic [XLEN-1:0] target;
  logic            push, push_ea, push_eb;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_inst;

  assign redirect     = (if_pc_sel_i == 2'b01) || (if_pc_sel_i == 2'b10);
  assign target       = (if_pc_sel_i == 2'b01) ? pc_branch_address_i : pc_jump_address_i;
  assign fifo_empty   = (count_q == '0);
  assign pop          = !redirect && !if_stall_i && !fifo_empty;
  assign count_popped = count_q - CW'(pop);
  assign space        = (count_popped < DEPTH_C);
  assign count_after  = count_popped + CW'(push);
  assign resp         = iwbm_ack_i | iwbm_err_i;
  assign addr_plus4   = addr_q + FOUR;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (fetch_pc_q[1:0] != 2'b00) begin
          if (space) state_d = S_HALT;
        end else if (space) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = resp ? S_IDLE : S_DRAIN;
        end else if (iwbm_err_i) begin
          state_d = S_HALT;
        end else if (iwbm_ack_i) begin
          fetch_pc_d = addr_plus4;
          // Back-to-back requests only while the FIFO keeps room after this edge.
          if ((count_after < DEPTH_C) && (addr_plus4[1:0] == 2'b00)) addr_d = addr_plus4;
          else                                                      state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = target;
        if (resp)     state_d    = S_IDLE;
      end
      S_HALT: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iwbm_cyc_o = (state_q == S_WAIT) || (state_q == S_DRAIN);
    iwbm_stb_o = iwbm_cyc_o;
    push       = 1'b0;
    push_pc    = addr_q;
    push_inst  = NOP;
    push_ea    = 1'b0;
    push_eb    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect && (fetch_pc_q[1:0] != 2'b00) && space) begin
          push    = 1'b1;
          push_pc = fetch_pc_q;
          push_ea = 1'b1;
        end
      end
      S_WAIT: begin
        if (!redirect && iwbm_err_i) begin
          push    = 1'b1;
          push_eb = 1'b1;
        end else if (!redirect && iwbm_ack_i) begin
          push      = 1'b1;
          push_inst = iwbm_dat_i;
        end
      end
      default: ;
    endcase
  end

  assign iwbm_addr_o = addr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC_X;
      addr_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_after;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= push_pc;
      fifo_inst_q[wr_ptr_q] <= push_inst;
      fifo_ea_q[wr_ptr_q]   <= push_ea;
      fifo_eb_q[wr_ptr_q]   <= push_eb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_valid_o       <= 1'b0;
      id_instruction_o <= NOP;
      id_pc_o          <= '0;
      id_pc_add4_o     <= '0;
      id_exc_addr_o    <= 1'b0;
      id_exc_bus_o     <= 1'b0;
    end else if (redirect || (!if_stall_i && fifo_empty)) begin
      id_valid_o       <= 1'b0;
      id_instruction_o <= NOP;
      id_exc_addr_o    <= 1'b0;
      id_exc_bus_o     <= 1'b0;
    end else if (!if_stall_i) begin
      id_valid_o       <= 1'b1;
      id_instruction_o <= fifo_inst_q[rd_ptr_q];
      id_pc_o          <= fifo_pc_q[rd_ptr_q];
      id_pc_add4_o     <= fifo_pc_q[rd_ptr_q] + FOUR;
      id_exc_addr_o    <= fifo_ea_q[rd_ptr_q];
      id_exc_bus_o     <= fifo_eb_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: directed fetch, stall, redirect, exception and reset scenarios
// against a behavioural Wishbone memory that returns the address as data.
module tb_if_prefetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] br = '0;
  logic [31:0] jp = '0;
  logic [31:0] addr, dat, id_inst, id_pc, id_add4;
  logic        cyc, stb, ack, err, hit, id_valid, id_ea, id_eb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .if_stall_i(stall), .if_pc_sel_i(sel),
    .pc_branch_address_i(br), .pc_jump_address_i(jp),
    .iwbm_addr_o(addr), .iwbm_cyc_o(cyc), .iwbm_stb_o(stb),
    .iwbm_dat_i(dat), .iwbm_ack_i(ack), .iwbm_err_i(err),
    .id_instruction_o(id_inst), .id_pc_o(id_pc), .id_pc_add4_o(id_add4),
    .id_valid_o(id_valid), .id_exc_addr_o(id_ea), .id_exc_bus_o(id_eb)
  );

  // Memory: responds wait_n cycles after the strobe rises; err_addr errors when enabled.
  int unsigned wait_n = 0;
  int unsigned wcnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  assign hit = cyc && (wcnt == wait_n);
  assign ack = hit && !(err_en && addr == err_addr);
  assign err = hit && err_en && (addr == err_addr);
  assign dat = addr;
  always @(posedge clk) begin
    if (!cyc || ack || err) wcnt <= 0;
    else                    wcnt <= wcnt + 1;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ea;
    logic        eb;
  } exp_t;

  exp_t sbq[$];
  logic strict = 1'b0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic ea, input logic eb);
    return '{pc: pc, inst: inst, ea: ea, eb: eb};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares each instruction newly loaded into IF/ID against the queue head.
  logic mon_ld;
  exp_t mon_e;
  always begin
    @(posedge clk);
    mon_ld = rst_n && !stall && !(sel == 2'b01 || sel == 2'b10);
    #1;
    if (mon_ld && id_valid) begin
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        n_checks++;
        if ({id_pc, id_inst, id_ea, id_eb} !== mon_e || id_add4 !== mon_e.pc + 32'd4) begin
          n_fail++;
          $display("FAIL id_out: got pc=%h add4=%h inst=%h ea=%b eb=%b expected pc=%h add4=%h inst=%h ea=%b eb=%b",
                   id_pc, id_add4, id_inst, id_ea, id_eb,
                   mon_e.pc, mon_e.pc + 32'd4, mon_e.inst, mon_e.ea, mon_e.eb);
        end
      end else if (strict) begin
        n_checks++;
        n_fail++;
        $display("FAIL id_unexpected: got pc=%h valid=1 expected no instruction", id_pc);
      end
    end
  end

  task automatic redirect(input logic [1:0] s, input logic [31:0] t);
    if (s == 2'b01) br = t;
    else            jp = t;
    sel = s;
    @(negedge clk);
    sel = 2'b00;
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int c = 0;
    while (sbq.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},   64'(cyc),      64'd0);
    check({tag, "_stb"},   64'(stb),      64'd0);
    check({tag, "_valid"}, 64'(id_valid), 64'd0);
    check({tag, "_inst"},  64'(id_inst),  64'(NOP));
    check({tag, "_pc"},    64'(id_pc),    64'd0);
    check({tag, "_add4"},  64'(id_add4),  64'd0);
    check({tag, "_exc"},   64'({id_ea, id_eb}), 64'd0);
  endtask

  initial begin
    logic [31:0] frozen, stale;
    int acks, cycs, c;

    // Reset and first fetches
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 16; i++) sbq.push_back(mk(32'(i * 4), 32'(i * 4), 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cyc", 64'(cyc), 64'd1);
    check("first_addr", 64'(addr), 64'd0);
    @(negedge clk);
    check("latency_not_early", 64'(id_valid), 64'd0);
    @(negedge clk);
    check("latency_valid", 64'(id_valid), 64'd1);
    check("latency_pc", 64'(id_pc), 64'd0);
    check("latency_add4", 64'(id_add4), 64'd4);
    check("stream_addr", 64'(addr), 64'd8);
    repeat (4) @(negedge clk);

    // Stall: output freezes, FIFO fills to four entries and fetching pauses
    stall = 1'b1;
    frozen = id_pc;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    check("stall_pc_frozen", 64'(id_pc), 64'(frozen));
    check("stall_valid_held", 64'(id_valid), 64'd1);
    check("stall_fill_acks", 64'(acks), 64'd3);
    check("stall_bus_idle", 64'(cyc), 64'd0);
    stall = 1'b0;
    wait_empty("stream_drain", 40);

    // Branch while an ack is outstanding
    wait_n = 3;
    c = 0;
    while (!(cyc && wcnt == 1) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("pending_found", 64'(cyc && wcnt == 1), 64'd1);
    stale = addr;
    for (int i = 0; i < 4; i++) sbq.push_back(mk(32'h100 + 32'(i * 4), 32'h100 + 32'(i * 4), 1'b0, 1'b0));
    redirect(2'b01, 32'h100);
    check("br_bubble", 64'(id_valid), 64'd0);
    check("br_drain_cyc", 64'(cyc), 64'd1);
    check("br_drain_addr", 64'(addr), 64'(stale));
    @(negedge clk);
    check("br_stale_ack", 64'(ack), 64'd1);
    check("br_stale_addr", 64'(addr), 64'(stale));
    @(negedge clk);
    check("br_idle_after_drain", 64'(cyc), 64'd0);
    @(negedge clk);
    check("br_new_cyc", 64'(cyc), 64'd1);
    check("br_new_addr", 64'(addr), 64'h100);
    wait_empty("br_stream", 80);

    // Jump to a misaligned target: exception entry, then halt
    strict = 1'b1;
    sbq.push_back(mk(32'h102, NOP, 1'b1, 1'b0));
    redirect(2'b10, 32'h102);
    wait_empty("misalign_out", 40);
    cycs = 0;
    for (int i = 0; i < 10; i++) begin
      if (cyc) cycs++;
      @(negedge clk);
    end
    check("misalign_halted", 64'(cycs), 64'd0);

    // Resume from halt
    wait_n = 0;
    strict = 1'b0;
    sbq.push_back(mk(32'h200, 32'h200, 1'b0, 1'b0));
    sbq.push_back(mk(32'h204, 32'h204, 1'b0, 1'b0));
    redirect(2'b01, 32'h200);
    wait_empty("resume_stream", 40);

    // Bus error at 0x8
    err_en = 1'b1;
    err_addr = 32'h8;
    strict = 1'b1;
    sbq.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0));
    sbq.push_back(mk(32'h4, 32'h4, 1'b0, 1'b0));
    sbq.push_back(mk(32'h8, NOP, 1'b0, 1'b1));
    redirect(2'b01, 32'h0);
    wait_empty("buserr_out", 40);
    cycs = 0;
    for (int i = 0; i < 10; i++) begin
      if (cyc) cycs++;
      @(negedge clk);
    end
    check("buserr_halted", 64'(cycs), 64'd0);

    // Asynchronous reset in the middle of a bus cycle
    strict = 1'b0;
    err_en = 1'b0;
    wait_n = 3;
    redirect(2'b01, 32'h40);
    c = 0;
    while (!(id_valid && cyc) && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("midwait_found", 64'(id_valid && cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sbq.delete();
    @(negedge clk);
    wait_n = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) sbq.push_back(mk(32'(i * 4), 32'(i * 4), 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_cyc", 64'(cyc), 64'd1);
    check("restart_addr", 64'(addr), 64'd0);
    wait_empty("restart_stream", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with an internal prefetch FIFO and a Wishbone-classic instruction master port. It generates sequential/branch/jump PCs, fetches from instruction memory and buffers fetched words. It feeds the ID stage through a registered IF/ID output with valid, stall and flush handling. It flags misaligned fetch targets and bus errors as exceptions, which travel with the instruction.

Parameters:
XLEN, 32, width of PC and address paths (32 or 64)
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset (zero-extended to XLEN)
NOP, 32'h0000_0013, instruction word driven on bubbles

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
if_stall_i  in  1  ID cannot accept; hold IF/ID output register
if_pc_sel_i  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00
pc_branch_address_i  in  XLEN  branch target
pc_jump_address_i  in  XLEN  jump target
iwbm_addr_o  out  XLEN  fetch address
iwbm_cyc_o  out  1  bus cycle active
iwbm_stb_o  out  1  strobe (equals cyc_o)
iwbm_dat_i  in  32  fetched word
iwbm_ack_i  in  1  transfer done
iwbm_err_i  in  1  bus error
id_instruction_o  out  32  instruction to ID
id_pc_o  out  XLEN  instruction PC
id_pc_add4_o  out  XLEN  PC+4, wraps modulo 2^XLEN
id_valid_o  out  1  output register holds a real instruction
id_exc_addr_o  out  1  misaligned fetch target
id_exc_bus_o  out  1  bus error on fetch

Behaviour:
- Reset (rst_i low, async): fetch_pc=RESET_PC, FIFO empty, FSM=IDLE, cyc/stb=0, id_valid_o=0, id_instruction_o=NOP, id_pc_o=id_pc_add4_o=0, both exc outputs=0.
- FIFO entry = {pc, inst, exc_addr, exc_bus}. count in 0..DEPTH. Push on accepted bus response. Pop when IF/ID register loads. Simultaneous push/pop on a full FIFO is legal; count is unchanged.
- IF/ID register: redirect (sel 01/10) has priority and loads a bubble (valid=0, inst=NOP, exc=0) even if stalled. Otherwise, if stalled, it holds. Otherwise it loads the FIFO head and pops, or loads a bubble when the FIFO is empty.
- FSM:
  IDLE: if no redirect and space (count-pop < DEPTH) and fetch_pc[1:0]==0, drive cyc/stb with addr=fetch_pc and go to WAIT. If fetch_pc[1:0]!=0, push {fetch_pc, NOP, exc_addr=1} when space is available, then go to HALT.
  WAIT: cyc/stb held, address stable. On ack, push {addr, dat_i, 0, 0} and set fetch_pc+=4. Stay in WAIT with the new address if space remains after this cycle's push/pop and the new pc is aligned; otherwise go to IDLE. On err (err wins over ack), push {addr, NOP, 0, 1} and go to HALT.
  DRAIN: cyc/stb held until ack or err; response discarded; go to IDLE.
  HALT: no requests; leave only on redirect.
- Redirect (sel 01/10, one-cycle pulse), any state: flush FIFO (count=0, same edge), set fetch_pc=target. A push in the same cycle is dropped. If in WAIT and ack/err is not this cycle, go to DRAIN. If ack/err is this cycle, go to IDLE. From IDLE or HALT, go to IDLE. A redirect during DRAIN updates fetch_pc and stays in DRAIN.
- Latency, zero-wait memory: cyc rises the first edge after reset release. Data acked at edge k is in the FIFO after k and in id_* after k+1 (if not stalled). Sustained throughput is 1 instruction/cycle.
- fetch_pc wraps at 2^XLEN. The address never changes while cyc=1.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> iwbm_addr_o 0,4,8,...; id_pc_o 0 with id_valid_o=1 two edges after first ack; then one instruction per cycle; id_pc_add4_o=id_pc_o+4.
- Hold if_stall_i high 10 cycles -> id_* frozen; fetches stop at DEPTH=4 buffered; after release, PCs continue with no gap or duplicate.
- Branch to 0x100 while an ack is pending (3 wait states) -> FSM DRAINs, stale word discarded, one bubble on id_*, next valid id_pc_o=0x100, iwbm_addr_o=0x100 only after the stale ack.
- Jump to 0x102 -> no bus cycle issued; id_valid_o=1, id_pc_o=0x102, id_exc_addr_o=1, id_instruction_o=NOP; fetch halted until the next redirect to 0x200 resumes normal fetch.
- iwbm_err_i at addr 0x8 -> entry with id_exc_bus_o=1, id_pc_o=0x8; no further requests until redirect.
- Assert rst_i low mid-WAIT -> cyc/stb drop asynchronously, all outputs at reset values; after release, fetch restarts at RESET_PC.
